// File: rtl/sevenseg_scroller_if.sv
// Button input and display outputs of the scrolling seven-segment driver.
// The master side is the driver itself.
interface sevenseg_scroller_if;
  logic       clean_btn;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] ptr_out;

  modport master (
    input  clean_btn,
    output an,
    output seg,
    output dp,
    output ptr_out
  );

  modport slave (
    output clean_btn,
    input  an,
    input  seg,
    input  dp,
    input  ptr_out
  );
endinterface

// File: rtl/sevenseg_scroller.sv
// Four-digit multiplexed display scrolling the hex digits 0..F.
// A button press restarts the message and freezes scrolling while held.
module sevenseg_scroller #(
  parameter int REFRESH_CYCLES = 20000,
  parameter int DEAD_CYCLES    = 2000,
  parameter int SCROLL_CYCLES  = 25000000
) (
  input logic clk,
  input logic rst,
  sevenseg_scroller_if.master io
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int SW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] D_LIM  = RW'(DEAD_CYCLES);
  localparam logic [SW-1:0] S_LAST = SW'(SCROLL_CYCLES - 1);

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_sel;
  logic [SW-1:0] scroll_cnt;
  logic [3:0]    ptr;
  logic          btn_q;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  logic [3:0] ch;
  logic       btn_rise;

  assign ch       = ptr + {2'b00, digit_sel};
  assign btn_rise = io.clean_btn & ~btn_q;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    g = 7'b1111111;
    unique case (c)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
    end else if (refresh_cnt == R_LAST) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // A fresh press restarts the message and wins over a scroll step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scroll_cnt <= '0;
      ptr        <= 4'd0;
      btn_q      <= 1'b0;
    end else begin
      btn_q <= io.clean_btn;
      if (btn_rise) begin
        scroll_cnt <= '0;
        ptr        <= 4'd0;
      end else if (!io.clean_btn) begin
        if (scroll_cnt == S_LAST) begin
          scroll_cnt <= '0;
          ptr        <= ptr + 4'd1;
        end else begin
          scroll_cnt <= scroll_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= 4'b1111;
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
    end else begin
      an_r <= ~(4'b1000 >> digit_sel);
      if (refresh_cnt < D_LIM) begin
        seg_r <= 7'b1111111;
        dp_r  <= 1'b1;
      end else begin
        seg_r <= glyph(ch);
        dp_r  <= (ch != 4'd0);
      end
    end
  end

  assign io.an      = an_r;
  assign io.seg     = seg_r;
  assign io.dp      = dp_r;
  assign io.ptr_out = ptr;

endmodule

// File: tb/tb_sevenseg_scroller.sv
// Randomized and directed bench for sevenseg_scroller against
// a cycle-count reference model.
module tb_sevenseg_scroller;

  localparam int R = 8;
  localparam int D = 2;
  localparam int S = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sevenseg_scroller_if io ();

  sevenseg_scroller #(
    .REFRESH_CYCLES(R),
    .DEAD_CYCLES   (D),
    .SCROLL_CYCLES (S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io.master)
  );

  logic [6:0] font [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_chk = 0;
  int n_err = 0;

  // model: edges since reset, and button-low cycles since last restart
  int t    = 0;
  int act  = 0;
  bit bprev = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mptr();
    return (act / S) % 16;
  endfunction

  task automatic model_reset();
    t     = 0;
    act   = 0;
    bprev = 1'b0;
  endtask

  task automatic tick();
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic       b;
    logic       live;
    int         ph;
    int         d;
    int         c;
    ean  = 4'b1111;
    eseg = 7'b1111111;
    edp  = 1'b1;
    @(posedge clk);
    b    = io.clean_btn;
    live = rst;
    if (live) begin
      ph = t % R;
      d  = (t / R) % 4;
      c  = (mptr() + d) % 16;
      ean[3-d] = 1'b0;
      if (ph >= D) begin
        eseg = font[c];
        edp  = (c != 0);
      end
      if (b && !bprev) act = 0;
      else if (!b) act++;
      bprev = b;
      t++;
    end
    #1;
    check("an",  32'(io.an),      32'(ean));
    check("seg", 32'(io.seg),     32'(eseg));
    check("dp",  32'(io.dp),      32'(edp));
    check("ptr", 32'(io.ptr_out), live ? 32'(mptr()) : 32'd0);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(int target);
    for (int i = 0; i < 4000 && t < target; i++) tick();
    check("run_to_bound", 32'(t), 32'(target));
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    model_reset();
    ticks(3);
    check("rst_an",  32'(io.an),  32'h0F);
    check("rst_seg", 32'(io.seg), 32'h7F);
    check("rst_dp",  32'(io.dp),  32'h1);
    rst = 1'b1;
    tick();
    check("e1_an",  32'(io.an),  32'b0111);
    check("e1_seg", 32'(io.seg), 32'h7F);
    tick();
    check("e2_seg", 32'(io.seg), 32'h7F);
    tick();
    check("e3_seg", 32'(io.seg), 32'b0000001);
    check("e3_dp",  32'(io.dp),  32'h0);
    ticks(6);
    check("e9_an",  32'(io.an),  32'b1011);
    ticks(2);
    check("e11_seg", 32'(io.seg), 32'b1001111);
    check("e11_dp",  32'(io.dp),  32'h1);
  endtask

  initial begin
    int c;
    int g;
    io.clean_btn = 1'b0;
    #1;
    reset_seq();

    // scroll wrap
    run_to(S * 14);
    check("wrap_ptr14", 32'(io.ptr_out), 32'd14);
    for (int i = 0; i < 32; i++) begin
      tick();
      if (io.seg != 7'h7F) begin
        c = (io.an == 4'b0111) ? 14 :
            (io.an == 4'b1011) ? 15 :
            (io.an == 4'b1101) ? 0 : 1;
        check("wrap_seg", 32'(io.seg), 32'(font[c]));
        check("wrap_dp",  32'(io.dp),  32'(c != 0));
      end
    end
    run_to(S * 16);
    check("wrap_ptr0", 32'(io.ptr_out), 32'd0);

    // freeze at ptr 5
    run_to(S * 21);
    check("frz_pre", 32'(io.ptr_out), 32'd5);
    io.clean_btn = 1'b1;
    tick();
    check("frz_clr", 32'(io.ptr_out), 32'd0);
    for (int i = 1; i < 300; i++) begin
      tick();
      check("frz_hold", 32'(io.ptr_out), 32'd0);
    end
    io.clean_btn = 1'b0;
    ticks(63);
    check("frz_63", 32'(io.ptr_out), 32'd0);
    tick();
    check("frz_64", 32'(io.ptr_out), 32'd1);

    // press lands on the scroll step edge
    g = 0;
    while (act != 2 * S + S - 1 && g < 4000) begin
      tick();
      g++;
    end
    check("sim_reach", 32'(act), 32'(3 * S - 1));
    check("sim_pre", 32'(io.ptr_out), 32'd2);
    io.clean_btn = 1'b1;
    tick();
    check("sim_ptr", 32'(io.ptr_out), 32'd0);
    check("sim_cnt", 32'(dut.scroll_cnt), 32'd0);
    ticks(3);
    io.clean_btn = 1'b0;

    // async reset mid-operation
    g = 0;
    while (!(mptr() == 9 && t % R == 5) && g < 4000) begin
      tick();
      g++;
    end
    check("mid_ptr9", 32'(io.ptr_out), 32'd9);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_an",  32'(io.an),      32'h0F);
    check("mid_seg", 32'(io.seg),     32'h7F);
    check("mid_dp",  32'(io.dp),      32'h1);
    check("mid_ptr", 32'(io.ptr_out), 32'd0);
    check("mid_cnt", 32'(dut.refresh_cnt), 32'd0);
    reset_seq();

    // reset released with button held
    ticks(20);
    rst = 1'b0;
    model_reset();
    io.clean_btn = 1'b1;
    ticks(2);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("rb_hold", 32'(io.ptr_out), 32'd0);
    end
    io.clean_btn = 1'b0;
    ticks(63);
    check("rb_63", 32'(io.ptr_out), 32'd0);
    tick();
    check("rb_64", 32'(io.ptr_out), 32'd1);

    // random button activity
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) io.clean_btn = ~io.clean_btn;
      tick();
    end
    io.clean_btn = 1'b0;
    ticks(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
